glitch_burst_gen: RTL
=====================

// Module: glitch_burst_gen
// PURPOSE
//  Trigger-armed glitch generator with multi-pulse bursts; timing is programmed per shot, not fixed at build.
//  Sits between the PLL-clocked control logic (clk = PLL output) and the glitch output pad.
//  Per shot: wait DELAY, then emit PULSES pulses of WIDTH cycles, separated by GAP cycles.
//  Adds synchronised trigger, abort and explicit arm handshake.
// PARAMETERS
//  CNT_W          32  width of delay/width/gap counters and config inputs
//  PCNT_W         8   width of pulse-count config and pulse_idx
//  SYNC_STAGES    2   trigger synchroniser flops (>=2)
//  GLITCH_ACT     1   active level of glitch (0 = active-low output)
//  TIMEOUT_CYCLES 600_000_000  armed-wait limit (used only with GLITCH_TIMEOUT_EN)
// PORTS
//  clk              in  1       PLL clock, all logic on posedge
//  rst              in  1       synchronous, active-high reset
//  arm              in  1       request arming; accepted only in IDLE
//  trigger          in  1       asynchronous trigger input
//  abort            in  1       synchronous abort, any state
//  cfg_delay        in  CNT_W   delay cycles from trigger edge detect to first pulse
//  cfg_width        in  CNT_W   pulse high cycles (0 treated as 1)
//  cfg_gap          in  CNT_W   inactive cycles between pulses (0 treated as 1)
//  cfg_pulses       in  PCNT_W  pulses per burst (0 treated as 1)
//  glitch           out 1       glitch pulse output, level per GLITCH_ACT
//  armed            out 1       high in ARMED
//  delay_indicator  out 1       high in DELAY
//  done_indicator   out 1       high in DONE
//  timeout          out 1       one-cycle pulse on arm timeout (0 when macro off)
//  pulse_idx        out PCNT_W  index of current/last pulse, 0-based
// BEHAVIOUR
//  Reset: state=IDLE, glitch=!GLITCH_ACT, armed/delay_indicator/done_indicator/timeout=0, pulse_idx=0, counters 0.
//  All outputs registered. Trigger synchronised through SYNC_STAGES flops; rising edge = sync_out & ~prev.
//  States: IDLE, ARMED, DELAY, PULSE, GAP, DONE.
//   IDLE : arm=1 -> latch cfg_* into shadow regs, go ARMED. cfg_* changes afterwards have no effect on the shot.
//   ARMED: edge detected -> DELAY, counter=0. A trigger already high at arming is not an edge; it must fall first.
//   DELAY: counts 0..D-1; at count==D-1 -> PULSE (D=0: skip DELAY, ARMED->PULSE directly).
//   PULSE: glitch active for exactly W cycles; then (pulse_idx==P-1) ? DONE : GAP.
//   GAP  : glitch inactive for exactly G cycles; then pulse_idx++, -> PULSE.
//   DONE : done_indicator=1; trigger(sync)=0 -> IDLE. Re-arm required for next shot.
//  Latency: trigger high first sampled at edge E0 -> glitch active from edge E0+SYNC_STAGES+1+D.
//  Burst length (glitch first active to DONE entry) = P*W + (P-1)*G cycles.
//  abort=1 in any state: next edge -> IDLE, glitch inactive, done_indicator not set, pulse_idx held.
//  Priority: rst > abort > state transitions. arm outside IDLE ignored.
//  Trigger edges while in DELAY/PULSE/GAP/DONE ignored (no retrigger).
//  Counters are CNT_W wide and never wrap: max D = 2^CNT_W-1.
// CONFIGURATION
//  `GLITCH_TIMEOUT_EN defined: ARMED counts cycles; at TIMEOUT_CYCLES without trigger edge -> IDLE,
//    timeout pulses high one cycle. Counter cleared on every ARMED entry.
//  Not defined: ARMED waits indefinitely; timeout tied 0; no timeout counter logic synthesised.
// TESTING
//  1 rst; arm, D=10 W=5 P=1; trigger rises -> glitch active 13 cycles after E0 (SYNC=2), for 5 cycles; done.
//  2 D=0 W=3 G=2 P=4 -> pattern 3 on/2 off x4 (18 cycles), pulse_idx 0..3, done after 4th pulse.
//  3 W=0 G=0 P=0 -> treated as 1/1/1: single 1-cycle pulse.
//  4 abort mid-PULSE (pulse 2 of 4) -> glitch inactive next cycle, IDLE, done_indicator stays 0.
//  5 trigger held high while arming -> no shot until trigger falls then rises.
//  6 macro on, TIMEOUT_CYCLES=100, no trigger -> timeout pulse at cycle 100 of ARMED, IDLE; off: stays ARMED.

Source files
------------

// File: rtl/glitch_burst_gen.sv
// glitch_burst_gen: trigger-armed glitch generator that emits multi-pulse bursts.
// Latency: a trigger first sampled high at edge E0 drives glitch active from edge E0+SYNC_STAGES+1+delay.
// Backpressure: none. arm is honoured only in IDLE, and trigger edges outside ARMED are dropped.
//
// Per shot the block waits DELAY cycles, then emits PULSES pulses of WIDTH cycles separated
// by GAP cycles. Timing is latched per shot from cfg_*_i when arm is accepted in IDLE.
// Ports:
//   clk_i, rst_i          : PLL clock, synchronous active-high reset
//   arm_i                 : arming request (IDLE only)
//   trigger_i             : asynchronous trigger, synchronised internally
//   abort_i               : synchronous abort, returns to IDLE from any state
//   cfg_delay_i/width_i/gap_i/pulses_i : per-shot timing (width/gap/pulses of 0 act as 1)
//   glitch_o              : glitch pulse, active level GLITCH_ACT
//   armed_o, delay_indicator_o, done_indicator_o : state indicators
//   timeout_o             : one-cycle pulse when an armed wait times out
//   pulse_idx_o           : 0-based index of current/last pulse
// Optional feature: define GLITCH_TIMEOUT_EN to bound the ARMED wait to TIMEOUT_CYCLES.
// Without it ARMED waits forever and timeout_o is tied low.

module glitch_burst_gen #(
    parameter int          CNT_W          = 32,
    parameter int          PCNT_W         = 8,
    parameter int          SYNC_STAGES    = 2,
    parameter logic        GLITCH_ACT     = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 600_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              arm_i,
    input  logic              trigger_i,
    input  logic              abort_i,
    input  logic [CNT_W-1:0]  cfg_delay_i,
    input  logic [CNT_W-1:0]  cfg_width_i,
    input  logic [CNT_W-1:0]  cfg_gap_i,
    input  logic [PCNT_W-1:0] cfg_pulses_i,
    output logic              glitch_o,
    output logic              armed_o,
    output logic              delay_indicator_o,
    output logic              done_indicator_o,
    output logic              timeout_o,
    output logic [PCNT_W-1:0] pulse_idx_o
);

    // Elaboration-time sanity checks on the configuration.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("glitch_burst_gen: SYNC_STAGES must be at least 2");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("glitch_burst_gen: TIMEOUT_CYCLES must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Trigger synchroniser and rising-edge detect.
    // The edge flag is registered so the FSM only ever sees flopped data;
    // this extra stage accounts for the "+1" in the trigger-to-glitch latency.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   trig_prev_q;
    logic                   edge_q;
    logic                   trig_sync;

    assign trig_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q      <= '0;
            trig_prev_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], trigger_i};
            trig_prev_q <= trig_sync;
            edge_q      <= trig_sync & ~trig_prev_q;
        end
    end

    // ------------------------------------------------------------------
    // State, counters and per-shot shadow configuration
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [PCNT_W-1:0]   pulse_idx_q, pulse_idx_d;
    logic [CNT_W-1:0]    sh_delay_q, sh_delay_d;
    logic [CNT_W-1:0]    sh_width_q, sh_width_d;
    logic [CNT_W-1:0]    sh_gap_q, sh_gap_d;
    logic [PCNT_W-1:0]   sh_pulses_q, sh_pulses_d;

    // Registered outputs, computed from the next state so they line up
    // with the state they describe.
    logic glitch_q, glitch_d;
    logic armed_q, armed_d;
    logic delay_ind_q, delay_ind_d;
    logic done_ind_q, done_ind_d;

`ifdef GLITCH_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_idx_d = pulse_idx_q;
        sh_delay_d  = sh_delay_q;
        sh_width_d  = sh_width_q;
        sh_gap_d    = sh_gap_q;
        sh_pulses_d = sh_pulses_q;
`ifdef GLITCH_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        timeout_d   = 1'b0;
`endif

        if (abort_i) begin
            // Abort beats every transition; pulse_idx is deliberately kept
            // so software can see how far the burst got.
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        sh_delay_d  = cfg_delay_i;
                        sh_width_d  = (cfg_width_i == '0) ? CNT_W'(1) : cfg_width_i;
                        sh_gap_d    = (cfg_gap_i == '0) ? CNT_W'(1) : cfg_gap_i;
                        sh_pulses_d = (cfg_pulses_i == '0) ? PCNT_W'(1) : cfg_pulses_i;
                        pulse_idx_d = '0;
                        cnt_d       = '0;
                        state_d     = S_ARMED;
`ifdef GLITCH_TIMEOUT_EN
                        tmo_cnt_d   = '0;
`endif
                    end
                end

                S_ARMED: begin
                    // A trigger already high when arming produces no edge here:
                    // edge_q only fires on a low-to-high change of the synced level.
                    if (edge_q) begin
                        cnt_d   = '0;
                        state_d = (sh_delay_q == '0) ? S_PULSE : S_DELAY;
                    end
`ifdef GLITCH_TIMEOUT_EN
                    else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = S_IDLE;
                        timeout_d = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    end
`endif
                end

                S_DELAY: begin
                    if (cnt_q == sh_delay_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = S_PULSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_PULSE: begin
                    if (cnt_q == sh_width_q - CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = (pulse_idx_q == sh_pulses_q - PCNT_W'(1)) ? S_DONE : S_GAP;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_GAP: begin
                    if (cnt_q == sh_gap_q - CNT_W'(1)) begin
                        cnt_d       = '0;
                        pulse_idx_d = pulse_idx_q + PCNT_W'(1);
                        state_d     = S_PULSE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    // Hold DONE until the trigger is released so one trigger
                    // assertion can never fire two shots.
                    if (!trig_sync) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        glitch_d    = (state_d == S_PULSE) ? GLITCH_ACT : ~GLITCH_ACT;
        armed_d     = (state_d == S_ARMED);
        delay_ind_d = (state_d == S_DELAY);
        done_ind_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pulse_idx_q <= '0;
            sh_delay_q  <= '0;
            sh_width_q  <= '0;
            sh_gap_q    <= '0;
            sh_pulses_q <= '0;
            glitch_q    <= ~GLITCH_ACT;
            armed_q     <= 1'b0;
            delay_ind_q <= 1'b0;
            done_ind_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_idx_q <= pulse_idx_d;
            sh_delay_q  <= sh_delay_d;
            sh_width_q  <= sh_width_d;
            sh_gap_q    <= sh_gap_d;
            sh_pulses_q <= sh_pulses_d;
            glitch_q    <= glitch_d;
            armed_q     <= armed_d;
            delay_ind_q <= delay_ind_d;
            done_ind_q  <= done_ind_d;
        end
    end

`ifdef GLITCH_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign glitch_o          = glitch_q;
    assign armed_o           = armed_q;
    assign delay_indicator_o = delay_ind_q;
    assign done_indicator_o  = done_ind_q;
    assign pulse_idx_o       = pulse_idx_q;

endmodule
